// File: rtl/bbs_pkg.sv
// bbs_pkg -- shared definitions for the bouncing-box video source.
//
// Contents:
//   dir_t             per-axis motion direction (FWD = increasing coordinate)
//   DEFAULT_BOX_SIZE  default box edge length in pixels
//   DEFAULT_STEP      default box motion per frame in pixels
package bbs_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_t;

  localparam int DEFAULT_BOX_SIZE = 32;
  localparam int DEFAULT_STEP     = 2;

endpackage : bbs_pkg

// File: rtl/bbs_axis_bounce.sv
// bbs_axis_bounce -- box position and direction along one screen axis.
//
// The position moves by STEP once per update pulse and reverses at the
// screen edges. pos_next is the combinational next-state position so the
// parent can colour pixels of a new frame with the box already moved.
//
// Ports:
//   clk       pixel clock
//   rst_n     asynchronous active-low reset (pos = 0, direction FWD)
//   update    one-cycle pulse, advance the box by one frame
//   dim       active extent of this axis (width or height)
//   pos_next  position the box will hold after this clock edge
module bbs_axis_bounce
  import bbs_pkg::*;
#(
  parameter int LGDIM    = 11,
  parameter int BOX_SIZE = DEFAULT_BOX_SIZE,
  parameter int STEP     = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             update,
  input  logic [LGDIM-1:0] dim,
  output logic [LGDIM-1:0] pos_next
);

  // One extra bit so pos + BOX_SIZE + STEP never wraps before comparing.
  localparam int W = LGDIM + 1;
  localparam logic [W-1:0] BOX_W  = W'(BOX_SIZE);
  localparam logic [W-1:0] STEP_W = W'(STEP);

  dir_t             dir;
  dir_t             dir_next;
  logic [LGDIM-1:0] pos;
  logic [W-1:0]     pos_w;
  logic [W-1:0]     dim_w;

  assign pos_w = {1'b0, pos};
  assign dim_w = {1'b0, dim};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos <= '0;
      dir <= DIR_FWD;
    end else begin
      pos <= pos_next;
      dir <= dir_next;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    dir_next = dir;
    pos_next = pos;
    if (update) begin
      if (dim_w < BOX_W + STEP_W) begin
        // Screen too small to move in: park the box at the origin.
        pos_next = '0;
        dir_next = DIR_FWD;
      end else if (pos_w + BOX_W > dim_w) begin
        // Screen shrank under the box: pull it back inside and head home.
        pos_next = LGDIM'(dim_w - BOX_W);
        dir_next = DIR_REV;
      end else if (dir == DIR_FWD) begin
        if (pos_w + BOX_W + STEP_W > dim_w) begin
          pos_next = LGDIM'(pos_w - STEP_W);
          dir_next = DIR_REV;
        end else begin
          pos_next = LGDIM'(pos_w + STEP_W);
        end
      end else begin
        if (pos_w < STEP_W) begin
          pos_next = LGDIM'(pos_w + STEP_W);
          dir_next = DIR_FWD;
        end else begin
          pos_next = LGDIM'(pos_w - STEP_W);
        end
      end
    end
  end

endmodule : bbs_axis_bounce

// File: rtl/bounce_box_src.sv
// bounce_box_src -- test-pattern source: a solid box bouncing on a background.
//
// Tracks the raster position from the encoder's handshake strobes and
// returns the colour for that position. o_pixel is registered from the
// next-state position, so it already describes the new pixel in the cycle
// after i_rd / i_newline / i_newframe.
//
// Ports:
//   i_pixclk    pixel clock
//   i_reset_n   asynchronous active-low reset
//   i_width     active pixels per line
//   i_height    active lines per frame
//   i_rd        encoder consumed the current pixel (x + 1)
//   i_newline   start of next line (x = 0, y + 1)
//   i_newframe  start of next frame (x = y = 0, box moves one step)
//   i_bg        background colour {red, grn, blu}
//   i_fg        box colour {red, grn, blu}
//   o_pixel     colour of the current position
//   o_frame     frame counter, wraps at 255
module bounce_box_src
  import bbs_pkg::*;
#(
  parameter int BITS_PER_COLOR = 8,
  parameter int LGDIM          = 11,
  parameter int BOX_SIZE       = DEFAULT_BOX_SIZE,
  parameter int STEP           = DEFAULT_STEP
) (
  input  logic                      i_pixclk,
  input  logic                      i_reset_n,
  input  logic [LGDIM-1:0]          i_width,
  input  logic [LGDIM-1:0]          i_height,
  input  logic                      i_rd,
  input  logic                      i_newline,
  input  logic                      i_newframe,
  input  logic [3*BITS_PER_COLOR-1:0] i_bg,
  input  logic [3*BITS_PER_COLOR-1:0] i_fg,
  output logic [3*BITS_PER_COLOR-1:0] o_pixel,
  output logic [7:0]                o_frame
);

  localparam int W = LGDIM + 1;
  localparam logic [W-1:0]     BOX_W   = W'(BOX_SIZE);
  localparam logic [LGDIM-1:0] MAX_POS = '1;

  logic [LGDIM-1:0] x;
  logic [LGDIM-1:0] y;
  logic [LGDIM-1:0] x_next;
  logic [LGDIM-1:0] y_next;
  logic [LGDIM-1:0] bx_next;
  logic [LGDIM-1:0] by_next;
  logic             in_box;

  bbs_axis_bounce #(
    .LGDIM    (LGDIM),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_axis_x (
    .clk      (i_pixclk),
    .rst_n    (i_reset_n),
    .update   (i_newframe),
    .dim      (i_width),
    .pos_next (bx_next)
  );

  bbs_axis_bounce #(
    .LGDIM    (LGDIM),
    .BOX_SIZE (BOX_SIZE),
    .STEP     (STEP)
  ) u_axis_y (
    .clk      (i_pixclk),
    .rst_n    (i_reset_n),
    .update   (i_newframe),
    .dim      (i_height),
    .pos_next (by_next)
  );

  // Raster position; newframe beats newline beats rd. Counters stick at
  // their maximum instead of wrapping back into the visible area.
  always_comb begin
    x_next = x;
    y_next = y;
    if (i_newframe) begin
      x_next = '0;
      y_next = '0;
    end else if (i_newline) begin
      x_next = '0;
      y_next = (y == MAX_POS) ? y : y + 1'b1;
    end else if (i_rd) begin
      x_next = (x == MAX_POS) ? x : x + 1'b1;
    end
  end

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_next;
      y <= y_next;
    end
  end

  // Next-state position against next-state box: the first pixel of a new
  // frame already sees the moved box.
  assign in_box = ({1'b0, x_next} >= {1'b0, bx_next}) &&
                  ({1'b0, x_next} <  {1'b0, bx_next} + BOX_W) &&
                  ({1'b0, y_next} >= {1'b0, by_next}) &&
                  ({1'b0, y_next} <  {1'b0, by_next} + BOX_W);

  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_pixel <= '0;
      o_frame <= '0;
    end else begin
      o_pixel <= in_box ? i_fg : i_bg;
      if (i_newframe) begin
        o_frame <= o_frame + 8'd1;
      end
    end
  end

endmodule : bounce_box_src

// File: doc/bounce_box_src.md
BOUNCE_BOX_SRC -- requirements
Module: bounce_box_src

Interface
REQ-001 SHALL have parameter BITS_PER_COLOR, default 8, bits per colour channel.
REQ-002 SHALL have parameter LGDIM, default 11, coordinate and dimension width.
REQ-003 SHALL have parameter BOX_SIZE, default 32, box edge in pixels.
REQ-004 SHALL have parameter STEP, default 2, box motion per frame in pixels.
REQ-005 SHALL have port i_pixclk  in  1  pixel clock, the single clock.
REQ-006 SHALL have port i_reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_width  in  LGDIM  active pixels per line.
REQ-008 SHALL have port i_height  in  LGDIM  active lines per frame.
REQ-009 SHALL have port i_rd  in  1  downstream HDMI encoder consumed the current pixel.
REQ-010 SHALL have port i_newline  in  1  start of next line.
REQ-011 SHALL have port i_newframe  in  1  start of next frame.
REQ-012 SHALL have port i_bg  in  3*BITS_PER_COLOR  background RGB.
REQ-013 SHALL have port i_fg  in  3*BITS_PER_COLOR  box RGB.
REQ-014 SHALL have port o_pixel  out  3*BITS_PER_COLOR  RGB {red,grn,blu} for the current position.
REQ-015 SHALL have port o_frame  out  8  frame counter.

Function
REQ-016 SHALL keep x,y counters: i_newframe sets x=0,y=0; else i_newline sets x=0,y=y+1; else i_rd sets x=x+1.
REQ-017 SHALL apply priority i_newframe > i_newline > i_rd when they are asserted in the same cycle.
REQ-018 SHALL saturate x at 2^LGDIM-1 and y at 2^LGDIM-1, with no wrap.
REQ-019 SHALL register o_pixel from the next-state x,y, so o_pixel is valid for the new position one cycle after any counter update; this is zero effective latency to the consumer.
REQ-020 SHALL drive o_pixel=i_fg when bx<=x<bx+BOX_SIZE and by<=y<by+BOX_SIZE, else i_bg.
REQ-021 SHALL update the box position (bx,by) and the direction state exactly once per i_newframe cycle, using the values held before the update.
REQ-022 SHALL implement a 2-state FSM per axis (FWD, REV) with these transitions:
- FWD: if pos+BOX_SIZE+STEP > dim, go to REV and set pos=pos-STEP; else pos=pos+STEP.
- REV: if pos < STEP, go to FWD and set pos=pos+STEP; else pos=pos-STEP.
REQ-023 SHALL, on i_newframe with pos+BOX_SIZE > dim, clamp pos to dim-BOX_SIZE and enter REV; this overrides REQ-022.
REQ-024 SHALL hold pos=0 in FWD when dim < BOX_SIZE+STEP.
REQ-025 SHALL increment o_frame on each i_newframe, wrapping 255->0.
REQ-026 SHALL use unsigned arithmetic, with all comparisons done at LGDIM+1 bits to avoid overflow.

Reset
REQ-027 SHALL, while i_reset_n=0, asynchronously force: x=y=0, bx=by=0, both axes FWD, o_frame=0, o_pixel=0.
REQ-028 SHALL use the first post-reset i_newframe as a normal update (bx=by=STEP).

Structure
REQ-029 SHALL place the FWD/REV encoding and the default BOX_SIZE/STEP constants in shared package bbs_pkg.
REQ-030 SHALL implement the per-axis FSM as sub-module bbs_axis_bounce, instantiated twice (x with i_width, y with i_height).

Verification
REQ-031 SHALL cover reset and first frame: reset released, width 640, height 480, fg=FF0000, bg=000000; after reset o_pixel=000000; first frame (0,0)->FF0000, (32,0)->000000, (0,32)->000000.
REQ-032 SHALL cover horizontal/vertical bounce: 304 newframes give bx=608 FWD; the next gives bx=606 REV; by reverses at 448->446 on newframe 225.
REQ-033 SHALL cover the left bounce: bx=0 in REV on newframe gives bx=2, FWD.
REQ-034 SHALL cover simultaneous events: newframe+newline+rd in one cycle at x=100,y=50 gives x=0,y=0, exactly one box step, and o_frame+1.
REQ-035 SHALL cover async reset mid-line: i_reset_n low at x=100 gives o_pixel=0 and counters 0 without a clock edge.
REQ-036 SHALL cover a width shrink: width 640->320 with bx=400 gives bx=288, REV, on the next newframe.
